clk_reset_gen: RTL and testbench



---
 rtl/clk_reset_gen.sv | 133 +++++++++++++
 tb/tb_clk_reset_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/clk_reset_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// clk_reset_gen : divides x1 into non-overlapping phi1/phi2 plus clk_out and
//                 releases synchronised core/peripheral resets after a hold.
// Revision      : 1.0
// ============================================================================
module clk_reset_gen #(
   parameter int DIV         = 2,
   parameter int GAP         = 0,
   parameter int SYNC_STAGES = 2,
   parameter int RST_HOLD    = 3
) (
   input  logic x1,
   input  logic resetn_in,
   input  logic clk_stop,
   output logic phi1,
   output logic phi2,
   output logic clk_out,
   output logic reset,
   output logic reset_out,
   output logic clk_stopped
);

   localparam int CNT_W = $clog2(DIV);
   localparam int PER_W = $clog2(RST_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PER_W-1:0]       per_q, per_d;
   logic                   run_q, run_d;
   logic                   stopped_q, stopped_d;
   logic                   reset_q, reset_d;
   logic                   reset_out_q, reset_out_d;
   logic                   phi1_q, phi1_d;
   logic                   phi2_q, phi2_d;
   logic                   clk_out_q, clk_out_d;
   logic                   wrap;
   logic                   phases_on;
   logic [2:0]             dec;

   // {phi1, phi2, clk_out} for a given phase count
   function automatic logic [2:0] decode(input int c);
      logic [2:0] d;
      d[2] = (c >= GAP) && (c <= DIV/2 - 1);
      d[1] = (c >= DIV/2 + GAP) && (c <= DIV - 1);
      d[0] = (c < DIV/2);
      return d;
   endfunction

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], 1'b1};
      run_d       = run_q;
      cnt_d       = cnt_q;
      per_d       = per_q;
      stopped_d   = stopped_q;
      reset_d     = reset_q;
      reset_out_d = reset_out_q;
      phases_on   = 1'b0;
      wrap        = run_q && !stopped_q && (cnt_q == CNT_LAST);

      if (!run_q) begin
         if (sync_q[SYNC_STAGES-1]) begin
            run_d     = 1'b1;
            cnt_d     = '0;
            phases_on = 1'b1;
         end
      end else if (stopped_q) begin
         if (!clk_stop) begin
            stopped_d = 1'b0;
            cnt_d     = '0;
            phases_on = 1'b1;
         end
      end else if (wrap && clk_stop && !reset_q) begin
         // Stop only replaces a whole period, so no runt pulse can appear
         stopped_d = 1'b1;
         cnt_d     = '0;
      end else begin
         cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
         phases_on = 1'b1;
      end

      if (wrap) begin
         if (reset_q) begin
            if (int'(per_q) + 1 >= RST_HOLD) reset_d = 1'b0;
            else                              per_d   = per_q + PER_W'(1);
         end else begin
            reset_out_d = 1'b0;
         end
      end

      dec       = phases_on ? decode(int'(cnt_d)) : 3'b000;
      phi1_d    = dec[2];
      phi2_d    = dec[1];
      clk_out_d = dec[0];
   end

   always_ff @(posedge x1 or negedge resetn_in) begin
      if (!resetn_in) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         per_q       <= '0;
         run_q       <= 1'b0;
         stopped_q   <= 1'b0;
         reset_q     <= 1'b1;
         reset_out_q <= 1'b1;
         phi1_q      <= 1'b0;
         phi2_q      <= 1'b0;
         clk_out_q   <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         per_q       <= per_d;
         run_q       <= run_d;
         stopped_q   <= stopped_d;
         reset_q     <= reset_d;
         reset_out_q <= reset_out_d;
         phi1_q      <= phi1_d;
         phi2_q      <= phi2_d;
         clk_out_q   <= clk_out_d;
      end
   end

   assign phi1        = phi1_q;
   assign phi2        = phi2_q;
   assign clk_out     = clk_out_q;
   assign reset       = reset_q;
   assign reset_out   = reset_out_q;
   assign clk_stopped = stopped_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_reset_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_clk_reset_gen : scoreboard bench driving three parameterisations of
//                    clk_reset_gen from one x1 clock.
// Revision         : 1.1
// ============================================================================
module tb_clk_reset_gen;

    logic x1 = 1'b0;
    always #5 x1 = ~x1;

    logic rn0, rn1, rn2;
    logic cs0, cs1, cs2;
    logic p1_0, p2_0, co_0, r_0, ro_0, st_0;
    logic p1_1, p2_1, co_1, r_1, ro_1, st_1;
    logic p1_2, p2_2, co_2, r_2, ro_2, st_2;

    clk_reset_gen u_d0 (
        .x1(x1), .resetn_in(rn0), .clk_stop(cs0),
        .phi1(p1_0), .phi2(p2_0), .clk_out(co_0),
        .reset(r_0), .reset_out(ro_0), .clk_stopped(st_0)
    );

    clk_reset_gen #(.DIV(4), .GAP(1), .SYNC_STAGES(2), .RST_HOLD(2)) u_d1 (
        .x1(x1), .resetn_in(rn1), .clk_stop(cs1),
        .phi1(p1_1), .phi2(p2_1), .clk_out(co_1),
        .reset(r_1), .reset_out(ro_1), .clk_stopped(st_1)
    );

    clk_reset_gen #(.SYNC_STAGES(3)) u_d2 (
        .x1(x1), .resetn_in(rn2), .clk_stop(cs2),
        .phi1(p1_2), .phi2(p2_2), .clk_out(co_2),
        .reset(r_2), .reset_out(ro_2), .clk_stopped(st_2)
    );

    // Vector order: {phi1, phi2, clk_out, clk_stopped, reset, reset_out}
    typedef struct {
        int         inst;
        int         edge_n;
        logic [5:0] exp;
    } sb_t;

    sb_t        sb[$];
    sb_t        cur;
    logic [5:0] act;
    int         n_tests = 0;
    int         n_fail  = 0;
    event       chk_ev;

    // Per-position {phi1, phi2, clk_out}
    logic [2:0] pat2 [2];
    logic [2:0] pat4 [4];

    function automatic logic [5:0] outv(input int inst);
        case (inst)
            0:       return {p1_0, p2_0, co_0, st_0, r_0, ro_0};
            1:       return {p1_1, p2_1, co_1, st_1, r_1, ro_1};
            default: return {p1_2, p2_2, co_2, st_2, r_2, ro_2};
        endcase
    endfunction

    function automatic logic [5:0] exp_run(input int e, input int start, input int div,
                                           input int rf, input int rof);
        logic [2:0] ph;
        ph = 3'b000;
        if (e >= start) ph = (div == 2) ? pat2[(e - start) % 2] : pat4[(e - start) % 4];
        return {ph, 1'b0, (e < rf), (e < rof)};
    endfunction

    // Instance 0 runs freely until edge 20, then sees two stop requests.
    function automatic logic [5:0] exp_d0(input int e);
        if (e <= 20) return exp_run(e, 3, 2, 9, 11);
        case (e)
            21, 24, 25: return 6'b000100;
            22, 26:     return 6'b101000;
            default:    return 6'b010000;
        endcase
    endfunction

    task automatic push(input int inst, input int e, input logic [5:0] x);
        sb_t t;
        t.inst   = inst;
        t.edge_n = e;
        t.exp    = x;
        sb.push_back(t);
    endtask

    always begin
        @(negedge x1 or chk_ev);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = outv(cur.inst);
            n_tests++;
            if (act !== cur.exp) begin
                n_fail++;
                $display("FAIL outputs inst%0d edge%0d: got %b expected %b (phi1 phi2 clk_out stopped reset reset_out)",
                         cur.inst, cur.edge_n, act, cur.exp);
            end
        end
    end

    always @(negedge x1) begin
        n_tests++;
        if (((p1_0 & p2_0) | (p1_1 & p2_1) | (p1_2 & p2_2)) !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap at %0t: phi1/phi2 d0=%b%b d1=%b%b d2=%b%b",
                     $time, p1_0, p2_0, p1_1, p2_1, p1_2, p2_2);
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pat2[0] = 3'b101; pat2[1] = 3'b010;
        pat4[0] = 3'b001; pat4[1] = 3'b101; pat4[2] = 3'b000; pat4[3] = 3'b010;
        rn0 = 1'b0; rn1 = 1'b0; rn2 = 1'b0;
        cs0 = 1'b0; cs1 = 1'b1; cs2 = 1'b0;

        repeat (3) begin
            @(posedge x1); #1;
            for (int i = 0; i < 3; i++) push(i, 0, 6'b000011);
        end

        while ($time < 560) @(negedge x1);
        rn0 = 1'b1; rn1 = 1'b1; rn2 = 1'b1;

        for (int e = 1; e <= 27; e++) begin
            @(posedge x1); #1;
            push(0, e, exp_d0(e));
            push(1, e, exp_run(e, 3, 4, 11, 15));
            push(2, e, exp_run(e, 4, 2, 10, 12));
            cs0 = (e == 20) || (e == 22) || (e == 23) || (e == 24);
            cs1 = (e <= 10);
        end

        // Short resetn_in glitch on instance 0 while phi2 is high
        @(negedge x1); #1;
        rn0 = 1'b0;
        #1;
        push(0, 0, 6'b000011);
        -> chk_ev;
        #2;
        rn0 = 1'b1;

        for (int e = 1; e <= 12; e++) begin
            @(posedge x1); #1;
            push(0, e, exp_run(e, 3, 2, 9, 11));
            push(1, e + 27, exp_run(e + 27, 3, 4, 11, 15));
            push(2, e + 27, exp_run(e + 27, 4, 2, 10, 12));
        end

        @(negedge x1); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail == 0) $display("PASS");
        else             $display("FAIL %0d mismatches", n_fail);
        $finish;
    end

endmodule
`default_nettype wire
